ddfs_ftw_load_ctrl: RTL and testbench

Two-requester controller for the 48-bit frequency-tuning-word (FTW) load register that feeds the DDFS phase accumulator. It arbitrates between the host configuration path and the sweep engine using round-robin order. It sequences each winning word into the load register as a single-cycle enable pulse, then acknowledges the requester. Optionally, it defers the load to the next accumulator wrap so that frequency changes stay phase-continuous.

---
 rtl/ddfs_ftw_load_ctrl.sv | 101 ++++++++++
 tb/tb_ddfs_ftw_load_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddfs_ftw_load_ctrl.sv
// ddfs_ftw_load_ctrl: round-robin host/sweep arbiter sequencing 48-bit FTW words into the DDFS load register.
// Define DDFS_FTW_SYNC_LOAD_EN to defer each load to the next accumulator Wrap, bounded by SYNC_TIMEOUT.
module ddfs_ftw_load_ctrl #(
    parameter int WIDTH        = 48,
    parameter int SYNC_TIMEOUT = 1023
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             req_h_i,
    input  logic [WIDTH-1:0] din_h_i,
    output logic             ack_h_o,
    input  logic             req_s_i,
    input  logic [WIDTH-1:0] din_s_i,
    output logic             ack_s_o,
    input  logic             wrap_i,
    output logic             load_en_o,
    output logic [WIDTH-1:0] load_dout_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACK
`ifdef DDFS_FTW_SYNC_LOAD_EN
        , WAIT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             gnt_s_q, gnt_s_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             load_en_q, ack_h_q, ack_s_q;

`ifdef DDFS_FTW_SYNC_LOAD_EN
    localparam logic [15:0] TMO_LAST = 16'(SYNC_TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
`else
    localparam int unused_sync_timeout = SYNC_TIMEOUT;
    logic unused_wrap;
    assign unused_wrap = wrap_i;
`endif

    // gnt_s_q doubles as the round-robin "last granted" flag
    always_comb begin
        state_d = state_q;
        gnt_s_d = gnt_s_q;
        dout_d  = dout_q;
`ifdef DDFS_FTW_SYNC_LOAD_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (req_h_i || req_s_i) begin
                gnt_s_d = req_h_i && req_s_i ? !gnt_s_q : req_s_i;
                dout_d  = gnt_s_d ? din_s_i : din_h_i;
`ifdef DDFS_FTW_SYNC_LOAD_EN
                cnt_d   = '0;
                state_d = WAIT;
`else
                state_d = LOAD;
`endif
            end
`ifdef DDFS_FTW_SYNC_LOAD_EN
            WAIT: if (wrap_i || cnt_q == TMO_LAST) state_d = LOAD;
                  else cnt_d = cnt_q + 16'd1;
`endif
            LOAD:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            gnt_s_q   <= 1'b1;
            dout_q    <= '0;
            load_en_q <= 1'b0;
            ack_h_q   <= 1'b0;
            ack_s_q   <= 1'b0;
`ifdef DDFS_FTW_SYNC_LOAD_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_s_q   <= gnt_s_d;
            dout_q    <= dout_d;
            load_en_q <= state_d == LOAD;
            ack_h_q   <= state_d == ACK && !gnt_s_d;
            ack_s_q   <= state_d == ACK && gnt_s_d;
`ifdef DDFS_FTW_SYNC_LOAD_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign load_en_o   = load_en_q;
    assign load_dout_o = dout_q;
    assign ack_h_o     = ack_h_q;
    assign ack_s_o     = ack_s_q;
    assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_ddfs_ftw_load_ctrl.sv
// tb_ddfs_ftw_load_ctrl: randomized and directed checks of the FTW load controller against a transaction-level model.
// Sync-load scenarios run only when DDFS_FTW_SYNC_LOAD_EN is defined.
module tb_ddfs_ftw_load_ctrl;
`ifdef DDFS_FTW_SYNC_LOAD_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1023;
`endif
    logic        clk = 0, rst = 1, req_h = 0, req_s = 0, wrap = 0;
    logic [47:0] din_h = '0, din_s = '0, dout;
    logic        ack_h, ack_s, load_en, busy;
    int          vectors = 0, miscompares = 0;

    ddfs_ftw_load_ctrl #(.WIDTH(48), .SYNC_TIMEOUT(TMO)) dut (
        .clock_i(clk), .reset_i(rst), .req_h_i(req_h), .din_h_i(din_h), .ack_h_o(ack_h),
        .req_s_i(req_s), .din_s_i(din_s), .ack_s_o(ack_s), .wrap_i(wrap),
        .load_en_o(load_en), .load_dout_o(dout), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_h = 0; req_s = 0; wrap = 0; rst = 1;
        tick;
        rst = 0;
    endtask

    task automatic test_reset;
        int bad;
        #3;
        vectors++;
        if ({load_en, ack_h, ack_s, busy, dout} !== 52'h0) begin
            miscompares++; $display("FAIL reset_init got %h want 0", {load_en, ack_h, ack_s, busy, dout});
        end
        tick;
        rst = 0; req_h = 1; din_h = 48'hDEAD_BEEF_0001;
        tick;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy got %b want 1", busy); end
        #2 rst = 1;
        #1;
        vectors++;
        if ({load_en, ack_h, ack_s, busy, dout} !== 52'h0) begin
            miscompares++; $display("FAIL reset_async got %h want 0", {load_en, ack_h, ack_s, busy, dout});
        end
        req_h = 0;
        tick;
        rst = 0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (load_en || ack_h || ack_s) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL reset_noload got %0d pulses want 0", bad); end
    endtask

`ifndef DDFS_FTW_SYNC_LOAD_EN
    task automatic test_single_host;
        do_reset;
        req_h = 1; din_h = 48'h0000_1000_0000;
        tick;
        vectors++;
        if ({load_en, ack_h, ack_s, busy, dout} !== {4'b1001, 48'h0000_1000_0000}) begin
            miscompares++; $display("FAIL host_load got %h want %h", {load_en, ack_h, ack_s, busy, dout}, {4'b1001, 48'h0000_1000_0000});
        end
        tick;
        vectors++;
        if ({load_en, ack_h, ack_s, busy} !== 4'b0101) begin
            miscompares++; $display("FAIL host_ack got %b want 0101", {load_en, ack_h, ack_s, busy});
        end
        req_h = 0;
        tick;
        vectors++;
        if ({load_en, ack_h, ack_s, busy, dout} !== {4'b0000, 48'h0000_1000_0000}) begin
            miscompares++; $display("FAIL host_idle got %h want %h", {load_en, ack_h, ack_s, busy, dout}, {4'b0000, 48'h0000_1000_0000});
        end
    endtask

    task automatic test_back_to_back;
        int t_h, t_s, nload, both;
        logic [47:0] seq [2];
        do_reset;
        req_h = 1; req_s = 1; din_h = 48'h1; din_s = 48'h2;
        t_h = -1; t_s = -1; nload = 0; both = 0; seq[0] = '0; seq[1] = '0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (load_en && nload < 2) begin seq[nload] = dout; nload++; end
            if (ack_h && ack_s) both++;
            if (ack_h) begin t_h = c; req_h = 0; end
            if (ack_s) begin t_s = c; req_s = 0; end
        end
        vectors++;
        if (nload != 2 || seq[0] !== 48'h1 || seq[1] !== 48'h2) begin
            miscompares++; $display("FAIL tie_order got n=%0d %h,%h want n=2 1,2", nload, seq[0], seq[1]);
        end
        vectors++;
        if (t_h < 0 || t_s - t_h != 3 || both != 0) begin
            miscompares++; $display("FAIL tie_ack_gap got h=%0d s=%0d both=%0d want gap 3", t_h, t_s, both);
        end
        req_h = 1; req_s = 1; din_h = 48'h3; din_s = 48'h4;
        tick;
        vectors++;
        if (load_en !== 1'b1 || dout !== 48'h3) begin
            miscompares++; $display("FAIL tie_second got en=%b %h want en=1 3", load_en, dout);
        end
        for (int c = 0; c < 8; c++) begin
            tick;
            if (ack_h) req_h = 0;
            if (ack_s) req_s = 0;
        end
    endtask

    task automatic test_random;
        int phase;
        bit win_s, last_s, exp_load, exp_ah, exp_as;
        logic [47:0] exp_dout;
        do_reset;
        phase = 0; last_s = 1; win_s = 0; exp_dout = '0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            exp_load = 0; exp_ah = 0; exp_as = 0;
            if (phase == 0 && (req_h || req_s)) begin
                win_s    = (req_h && req_s) ? !last_s : req_s;
                last_s   = win_s;
                exp_dout = win_s ? din_s : din_h;
                exp_load = 1;
                phase    = 1;
            end else if (phase == 1) begin
                exp_ah = !win_s; exp_as = win_s; phase = 2;
            end else if (phase == 2) phase = 0;
            #1;
            vectors++;
            if ({load_en, ack_h, ack_s, busy, dout} !== {exp_load, exp_ah, exp_as, phase != 0, exp_dout}) begin
                miscompares++;
                $display("FAIL random_c%0d got %h want %h", c, {load_en, ack_h, ack_s, busy, dout},
                         {exp_load, exp_ah, exp_as, phase != 0, exp_dout});
            end
            if (ack_h) req_h = 0;
            else if (!req_h && $urandom_range(0, 3) == 0) begin req_h = 1; din_h = 48'({$urandom(), $urandom()}); end
            if (ack_s) req_s = 0;
            else if (!req_s && $urandom_range(0, 3) == 0) begin req_s = 1; din_s = 48'({$urandom(), $urandom()}); end
            wrap = 1'($urandom_range(0, 1));
        end
        req_h = 0; req_s = 0; wrap = 0;
    endtask
`else
    task automatic test_sync_wrap;
        int early;
        do_reset;
        req_s = 1; din_s = 48'hABCD_0000_0001; wrap = 1;
        tick;
        wrap = 0; early = 0;
        for (int k = 1; k < 5; k++) begin
            tick;
            if (load_en) early++;
        end
        wrap = 1;
        tick;
        wrap = 0;
        vectors++;
        if (early != 0 || load_en !== 1'b1 || dout !== 48'hABCD_0000_0001) begin
            miscompares++; $display("FAIL sync_wrap_load got early=%0d en=%b %h", early, load_en, dout);
        end
        tick;
        vectors++;
        if ({load_en, ack_h, ack_s} !== 3'b001) begin
            miscompares++; $display("FAIL sync_wrap_ack got %b want 001", {load_en, ack_h, ack_s});
        end
        req_s = 0;
        tick;
    endtask

    task automatic test_sync_timeout;
        int n;
        do_reset;
        req_h = 1; din_h = 48'h77;
        tick;
        n = 0;
        while (!load_en && n < 40) begin tick; n++; end
        vectors++;
        if (n != TMO || dout !== 48'h77) begin
            miscompares++; $display("FAIL sync_timeout got %0d cycles %h want %0d 77", n, dout, TMO);
        end
        tick;
        vectors++;
        if ({load_en, ack_h, ack_s} !== 3'b010) begin
            miscompares++; $display("FAIL sync_timeout_ack got %b want 010", {load_en, ack_h, ack_s});
        end
        req_h = 0;
        tick;
    endtask

    task automatic test_sync_reset;
        int bad, n;
        do_reset;
        req_h = 1; din_h = 48'h123;
        tick; tick; tick;
        #2 rst = 1;
        #1;
        vectors++;
        if (dout !== 48'h0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL sync_reset got %h busy=%b want 0", dout, busy);
        end
        req_h = 0;
        tick;
        rst = 0; bad = 0;
        for (int c = 0; c < 24; c++) begin
            tick;
            if (load_en || ack_h || ack_s) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL sync_reset_noload got %0d want 0", bad); end
        req_h = 1; din_h = 48'h55;
        n = 0;
        while (!load_en && n < 40) begin tick; n++; end
        vectors++;
        if (!load_en || dout !== 48'h55) begin
            miscompares++; $display("FAIL sync_reset_fresh got en=%b %h want 55", load_en, dout);
        end
        tick;
        vectors++;
        if (ack_h !== 1'b1) begin miscompares++; $display("FAIL sync_reset_ack got %b want 1", ack_h); end
        req_h = 0;
        tick;
    endtask
`endif

    initial begin
        test_reset;
`ifndef DDFS_FTW_SYNC_LOAD_EN
        test_single_host;
        test_back_to_back;
        test_random;
`else
        test_sync_wrap;
        test_sync_timeout;
        test_sync_reset;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
